// File: rtl/io_uart_fifo.sv
// 8N1 UART on the J1 I/O bus with RX/TX FIFOs, sticky status flags and a baud divisor.
// Optional IRQ-enable register and registered irq output when IO_UART_IRQ_EN is defined.
`timescale 1ns/1ps
module io_uart_fifo #(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [15:0] BASE_ADDR = 16'h4000,
    parameter int unsigned RX_DEPTH  = 16,
    parameter int unsigned TX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int          CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Bus protocol: io_rd/io_wr are single-cycle strobes qualified by io_addr; read data is
    // combinational in the strobe cycle, and every side effect (pop, push, flag clear)
    // commits on the clock edge that ends that cycle. No stall or ready exists.
    logic sel_rxdata, sel_txdata, sel_status, status_rd;
    assign sel_rxdata = (io_addr == BASE_ADDR);
    assign sel_txdata = (io_addr == BASE_ADDR + 16'd1);
    assign sel_status = (io_addr == BASE_ADDR + 16'd2);
    assign status_rd  = io_rd && sel_status;

    // RX FIFO
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wr_ptr, rx_rd_ptr, rx_level;
    logic         rx_empty, rx_full, rx_pop, rx_push_req, rx_push_ok, rx_overrun_evt;
    logic [7:0]   rx_head, rx_shift, rx_count8;

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RAW] != rx_rd_ptr[RAW]) &&
                      (rx_wr_ptr[RAW-1:0] == rx_rd_ptr[RAW-1:0]);
    assign rx_head  = rx_mem[rx_rd_ptr[RAW-1:0]];
    assign rx_pop   = io_rd && sel_rxdata && !rx_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign rx_push_ok     = rx_push_req && (!rx_full || rx_pop);
    assign rx_overrun_evt = rx_push_req && rx_full && !rx_pop;
    assign rx_level  = rx_wr_ptr - rx_rd_ptr;
    assign rx_count8 = (32'(rx_level) > 32'd255) ? 8'hFF : 8'(rx_level);

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wr_ptr[RAW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // TX FIFO
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wr_ptr, tx_rd_ptr;
    logic         tx_empty, tx_full, tx_push, tx_pop, tx_drop_evt, tx_idle;
    logic [7:0]   tx_head;
    uart_state_t  tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]   tx_bit;
    logic [7:0]   tx_shift;

    assign tx_empty    = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full     = (tx_wr_ptr[TAW] != tx_rd_ptr[TAW]) &&
                         (tx_wr_ptr[TAW-1:0] == tx_rd_ptr[TAW-1:0]);
    assign tx_head     = tx_mem[tx_rd_ptr[TAW-1:0]];
    assign tx_push     = io_wr && sel_txdata && !tx_full;
    assign tx_drop_evt = io_wr && sel_txdata && tx_full;
    assign tx_pop      = !tx_empty && ((tx_state == S_IDLE) ||
                                       (tx_state == S_STOP && tx_cnt == DIV_LAST));
    assign tx_idle     = tx_empty && (tx_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[TAW-1:0]] <= io_dout[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // TX FSM; a pop at the end of STOP chains straight into the next START.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                        uart_tx  <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                        uart_tx  <= tx_shift[0];
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_tx  <= tx_shift[1];
                        end
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_shift <= tx_head;
                            tx_state <= S_START;
                            uart_tx  <= 1'b0;
                        end else tx_state <= S_IDLE;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // RX path: 2-flop synchroniser plus a delayed copy for falling-edge detection.
    logic rx_s1, rx_s2, rx_prev, rx_ferr_evt;
    uart_state_t   rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_push_req <= 1'b0;
            rx_ferr_evt <= 1'b0;
        end else begin
            rx_s1       <= uart_rx;
            rx_s2       <= rx_s1;
            rx_prev     <= rx_s2;
            rx_push_req <= 1'b0;
            rx_ferr_evt <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else rx_bit <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt      <= '0;
                        rx_state    <= S_IDLE;
                        rx_push_req <= rx_s2;
                        rx_ferr_evt <= !rx_s2;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as a STATUS read wins over the clear.
    logic rx_overrun, tx_drop, frame_err;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rx_overrun_evt) rx_overrun <= 1'b1;
            else if (status_rd) rx_overrun <= 1'b0;
            if (tx_drop_evt)    tx_drop <= 1'b1;
            else if (status_rd) tx_drop <= 1'b0;
            if (rx_ferr_evt)    frame_err <= 1'b1;
            else if (status_rd) frame_err <= 1'b0;
        end
    end

    logic [15:0] status_word;
    assign status_word = {rx_count8, 2'b00, frame_err, tx_drop, rx_overrun,
                          tx_idle, tx_full, !rx_empty};

`ifdef IO_UART_IRQ_EN
    logic       sel_irqen;
    logic [1:0] irq_en;
    assign sel_irqen = (io_addr == BASE_ADDR + 16'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (io_wr && sel_irqen) irq_en <= io_dout[1:0];
            irq <= (irq_en[0] & !rx_empty) | (irq_en[1] & tx_idle) | rx_overrun;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        io_din = 16'h0000;
        if (io_rd) begin
            if (sel_rxdata)      io_din = rx_empty ? 16'h0000 : {8'h00, rx_head};
            else if (sel_status) io_din = status_word;
`ifdef IO_UART_IRQ_EN
            else if (sel_irqen)  io_din = {14'b0, irq_en};
`endif
        end
    end

    logic unused_dout;
    assign unused_dout = &{1'b0, io_dout[15:8]};

endmodule

// File: tb/tb_io_uart_fifo.sv
// Directed bench for io_uart_fifo at default parameters (DIV = 104).
`timescale 1ns/1ps
module tb_io_uart_fifo;

    localparam int DIV = 104;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_rd, io_wr;
    logic [15:0] io_addr, io_dout, io_din;
    logic        uart_rx, uart_tx, irq;

    int tests_run = 0;
    int tests_failed = 0;

    io_uart_fifo dut (
        .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start on a falling edge and return on the next one.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        io_addr = a; io_dout = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        io_addr = a; io_rd = 1'b1;
        #1 d = io_din;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic rx_bits(input logic [7:0] b);
        uart_rx = 1'b0;
        cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cycles(DIV);
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_bits(b);
        uart_rx = stop;
        cycles(DIV);
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  byte_rx;
        logic        irq_s;
        int          lat;
        int          got;

        reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0; io_dout = 16'h0; uart_rx = 1'b1;
        cycles(3);
        check("rst_tx", {15'b0, uart_tx}, 16'h0001);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        reset = 1'b0;
        cycles(2);
        read_check("rst_status", 16'h4002, 16'h0004);
        read_check("rst_rxdata", 16'h4000, 16'h0000);
        io_addr = 16'h4002;
        #1 check("din_no_rd", io_din, 16'h0000);
        @(negedge clk);
        read_check("unmapped_rd", 16'h5000, 16'h0000);

        // Test 1: single TX frame of 0x55
        bus_write(16'h4001, 16'h0155);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            if (uart_tx == 1'b0) begin lat = i; break; end
            @(negedge clk);
        end
        check("t1_start_latency", 16'(lat), 16'd1);
        read_check("t1_status_busy", 16'h4002, 16'h0000);
        cycles(102);
        check("t1_start_end", {15'b0, uart_tx}, 16'h0000);
        cycles(1);
        check("t1_bit0_edge", {15'b0, uart_tx}, 16'h0001);
        cycles(52);
        byte_rx = 8'h00;
        for (int b = 0; b < 8; b++) begin
            byte_rx[b] = uart_tx;
            cycles(104);
        end
        check("t1_byte", {8'h00, byte_rx}, 16'h0055);
        check("t1_stop", {15'b0, uart_tx}, 16'h0001);
        cycles(60);
        read_check("t1_status_idle", 16'h4002, 16'h0004);

        // Test 2: one received byte; tx_idle (bit2) is also set while TX is quiet
        rx_frame(8'hA5, 1'b1);
        read_check("t2_status", 16'h4002, 16'h0105);
`ifndef IO_UART_IRQ_EN
        check("t2_irq_tied", {15'b0, irq}, 16'h0000);
`endif
        read_check("t2_rxdata", 16'h4000, 16'h00A5);
        read_check("t2_rxempty", 16'h4000, 16'h0000);
        read_check("t2_status_after", 16'h4002, 16'h0004);

        // Test 3: overrun with 17 bytes
        for (int v = 0; v < 17; v++) rx_frame(8'(v), 1'b1);
        read_check("t3_status_ovr", 16'h4002, 16'h100D);
        read_check("t3_status_clr", 16'h4002, 16'h1005);
        for (int v = 0; v < 16; v++) read_check("t3_rxdata", 16'h4000, 16'(v));
        read_check("t3_status_end", 16'h4002, 16'h0004);

        // Test 4: 18 back-to-back writes; the first is taken by the FSM at once,
        // the next 16 fill the FIFO and the 18th is dropped
        for (int k = 0; k < 16; k++) bus_write(16'h4001, 16'(8'h30 + k));
        read_check("t4_not_full", 16'h4002, 16'h0000);
        bus_write(16'h4001, 16'h0040);
        read_check("t4_full", 16'h4002, 16'h0002);
        bus_write(16'h4001, 16'h0041);
        read_check("t4_drop", 16'h4002, 16'h0012);
        cycles(33);
        for (int f = 0; f < 17; f++) begin
            check("t4_start", {15'b0, uart_tx}, 16'h0000);
            byte_rx = 8'h00;
            for (int b = 0; b < 8; b++) begin
                cycles(104);
                byte_rx[b] = uart_tx;
            end
            check("t4_byte", {8'h00, byte_rx}, 16'(8'h30 + f));
            cycles(104);
            check("t4_stop", {15'b0, uart_tx}, 16'h0001);
            cycles(104);
        end
        check("t4_no_extra_frame", {15'b0, uart_tx}, 16'h0001);
        read_check("t4_status_end", 16'h4002, 16'h0004);

        // Test 5: framing error followed by a short glitch
        rx_frame(8'h3C, 1'b0);
        cycles(200);
        uart_rx = 1'b0;
        cycles(40);
        uart_rx = 1'b1;
        cycles(300);
        read_check("t5_status_ferr", 16'h4002, 16'h0024);
        read_check("t5_status_clr", 16'h4002, 16'h0004);
        read_check("t5_rxdata", 16'h4000, 16'h0000);

        // Test 6: reset in the middle of data bit 3
        bus_write(16'h4001, 16'h0000);
        bus_write(16'h4001, 16'h0000);
        cycles(468);
        check("t6_bit3_low", {15'b0, uart_tx}, 16'h0000);
        reset = 1'b1;
        #1 check("t6_async_tx", {15'b0, uart_tx}, 16'h0001);
        cycles(2);
        reset = 1'b0;
        cycles(1);
        read_check("t6_status", 16'h4002, 16'h0004);
        cycles(200);
        check("t6_line_idle", {15'b0, uart_tx}, 16'h0001);

`ifdef IO_UART_IRQ_EN
        bus_write(16'h4003, 16'h0001);
        read_check("irq_en_rd", 16'h4003, 16'h0001);
        check("irq_before", {15'b0, irq}, 16'h0000);
        rx_bits(8'h5A);
        uart_rx = 1'b1;
        got = 0;
        irq_s = 1'b1;
        for (int i = 0; i < 200; i++) begin
            io_addr = 16'h4002; io_rd = 1'b1;
            #1 d = io_din; irq_s = irq;
            @(negedge clk);
            io_rd = 1'b0;
            if (d[0]) begin got = 1; break; end
        end
        check("irq_push_seen", 16'(got), 16'd1);
        check("irq_not_early", {15'b0, irq_s}, 16'h0000);
        check("irq_one_cycle", {15'b0, irq}, 16'h0001);
        read_check("irq_rxdata", 16'h4000, 16'h005A);
        cycles(2);
        check("irq_cleared", {15'b0, irq}, 16'h0000);
`else
        read_check("off3_rd", 16'h4003, 16'h0000);
        bus_write(16'h4003, 16'h0003);
        read_check("off3_rd_after_wr", 16'h4003, 16'h0000);
        check("irq_off", {15'b0, irq}, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
